// File: rtl/phs_flow_tracker.sv
// PHS flow tracker: buffers parser header summaries in a small FIFO and looks up/allocates
// their 5-tuple in a fully-associative flow table, returning a per-flow result over valid/ready.
module phs_flow_tracker #(
    parameter int FLOW_ENTRIES  = 16,
    parameter int IN_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH     = 16,
    localparam int IDW = $clog2(FLOW_ENTRIES)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [119:0]         phs_i,
    input  logic                 phs_valid_i,
    input  logic                 flush_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [IDW-1:0]       flow_id_o,
    output logic                 flow_hit_o,
    output logic                 flow_new_o,
    output logic                 flow_evict_o,
    output logic [CNT_WIDTH-1:0] flow_pkt_cnt_o,
    output logic [7:0]           flow_tos_o,
    output logic                 fifo_full_o,
    output logic [15:0]          drop_cnt_o
);

    localparam int PW = (IN_FIFO_DEPTH > 1) ? $clog2(IN_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(IN_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESULT} state_t;

    state_t                state_q, state_d;

    logic [111:0]          fifo_mem_q [IN_FIFO_DEPTH];
    logic [111:0]          fifo_mem_d [IN_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  fifo_full_q, fifo_full_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  push, pop;
    logic [111:0]          head;

    logic [103:0]          ent_key_q [FLOW_ENTRIES];
    logic [103:0]          ent_key_d [FLOW_ENTRIES];
    logic [CNT_WIDTH-1:0]  ent_cnt_q [FLOW_ENTRIES];
    logic [CNT_WIDTH-1:0]  ent_cnt_d [FLOW_ENTRIES];
    logic [FLOW_ENTRIES-1:0] ent_valid_q, ent_valid_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  flush_pending_q, flush_pending_d;
    logic                  flush_apply;

    logic [103:0]          cur_key_q, cur_key_d;
    logic [7:0]            cur_tos_q, cur_tos_d;
    logic                  hit_q, hit_d;
    logic [IDW-1:0]        idx_q, idx_d;

    logic                  lk_hit, free_found;
    logic [IDW-1:0]        lk_idx, free_idx, alloc_idx;

    logic                  res_valid_q, res_valid_d;
    logic [IDW-1:0]        res_id_q, res_id_d;
    logic                  res_hit_q, res_hit_d;
    logic                  res_new_q, res_new_d;
    logic                  res_evict_q, res_evict_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
    logic [7:0]            res_tos_q, res_tos_d;

    // The tag byte travels with the PHS but plays no part in flow tracking.
    logic [7:0]            unused_tag;
    assign unused_tag = phs_i[119:112];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign head = fifo_mem_q[rd_ptr_q];
    assign pop  = (state_q == S_IDLE) && !flush_pending_q && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = phs_valid_i && (!fifo_full_q || pop);

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = phs_i[111:0];
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (phs_valid_i && !push && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
        count_d     = count_q + CW'(push) - CW'(pop);
        fifo_full_d = (count_d == CW'(IN_FIFO_DEPTH));
    end

    always_comb begin
        lk_hit     = 1'b0;
        lk_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < FLOW_ENTRIES; i++) begin
            if (!lk_hit && ent_valid_q[i] && (ent_key_q[i] == cur_key_q)) begin
                lk_hit = 1'b1;
                lk_idx = IDW'(i);
            end
            if (!free_found && !ent_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_key_d   = cur_key_q;
        cur_tos_d   = cur_tos_q;
        hit_d       = hit_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        ent_key_d   = ent_key_q;
        ent_cnt_d   = ent_cnt_q;
        ent_valid_d = ent_valid_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_hit_d   = res_hit_q;
        res_new_d   = res_new_q;
        res_evict_d = res_evict_q;
        res_cnt_d   = res_cnt_q;
        res_tos_d   = res_tos_q;
        flush_apply = 1'b0;
        alloc_idx   = '0;
        case (state_q)
            S_IDLE: begin
                if (flush_pending_q) begin
                    flush_apply = 1'b1;
                    ent_valid_d = '0;
                    rr_ptr_d    = '0;
                end else if (pop) begin
                    cur_key_d = head[103:0];
                    cur_tos_d = head[111:104];
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d   = lk_hit;
                idx_d   = lk_idx;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                res_valid_d = 1'b1;
                res_tos_d   = cur_tos_q;
                if (hit_q) begin
                    ent_cnt_d[idx_q] = sat_inc(ent_cnt_q[idx_q]);
                    res_id_d    = idx_q;
                    res_hit_d   = 1'b1;
                    res_new_d   = 1'b0;
                    res_evict_d = 1'b0;
                    res_cnt_d   = sat_inc(ent_cnt_q[idx_q]);
                end else begin
                    alloc_idx = free_found ? free_idx : rr_ptr_q;
                    ent_key_d[alloc_idx]   = cur_key_q;
                    ent_cnt_d[alloc_idx]   = CNT_WIDTH'(1);
                    ent_valid_d[alloc_idx] = 1'b1;
                    res_id_d    = alloc_idx;
                    res_hit_d   = 1'b0;
                    res_new_d   = 1'b1;
                    res_evict_d = !free_found;
                    res_cnt_d   = CNT_WIDTH'(1);
                    if (!free_found) rr_ptr_d = rr_ptr_q + IDW'(1);
                end
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        flush_pending_d = flush_i | (flush_pending_q & ~flush_apply);
    end

    // Storage arrays carry no reset; entry and FIFO validity is tracked separately.
    always_ff @(posedge CLK) begin
        fifo_mem_q <= fifo_mem_d;
        ent_key_q  <= ent_key_d;
        ent_cnt_q  <= ent_cnt_d;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fifo_full_q     <= 1'b0;
            drop_cnt_q      <= '0;
            ent_valid_q     <= '0;
            rr_ptr_q        <= '0;
            flush_pending_q <= 1'b0;
            cur_key_q       <= '0;
            cur_tos_q       <= '0;
            hit_q           <= 1'b0;
            idx_q           <= '0;
            res_valid_q     <= 1'b0;
            res_id_q        <= '0;
            res_hit_q       <= 1'b0;
            res_new_q       <= 1'b0;
            res_evict_q     <= 1'b0;
            res_cnt_q       <= '0;
            res_tos_q       <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            fifo_full_q     <= fifo_full_d;
            drop_cnt_q      <= drop_cnt_d;
            ent_valid_q     <= ent_valid_d;
            rr_ptr_q        <= rr_ptr_d;
            flush_pending_q <= flush_pending_d;
            cur_key_q       <= cur_key_d;
            cur_tos_q       <= cur_tos_d;
            hit_q           <= hit_d;
            idx_q           <= idx_d;
            res_valid_q     <= res_valid_d;
            res_id_q        <= res_id_d;
            res_hit_q       <= res_hit_d;
            res_new_q       <= res_new_d;
            res_evict_q     <= res_evict_d;
            res_cnt_q       <= res_cnt_d;
            res_tos_q       <= res_tos_d;
        end
    end

    assign res_valid_o    = res_valid_q;
    assign flow_id_o      = res_id_q;
    assign flow_hit_o     = res_hit_q;
    assign flow_new_o     = res_new_q;
    assign flow_evict_o   = res_evict_q;
    assign flow_pkt_cnt_o = res_cnt_q;
    assign flow_tos_o     = res_tos_q;
    assign fifo_full_o    = fifo_full_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_phs_flow_tracker.sv
// Directed bench for phs_flow_tracker: a reference flow-table model pushes expected results
// to a queue at stimulus time; results are popped and checked as the DUT presents them.
module tb_phs_flow_tracker;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic [119:0] phs_i = '0;
    logic         phs_valid_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         res_ready_i = 1'b1;

    logic         res_valid_o, flow_hit_o, flow_new_o, flow_evict_o, fifo_full_o;
    logic [3:0]   flow_id_o;
    logic [15:0]  flow_pkt_cnt_o, drop_cnt_o;
    logic [7:0]   flow_tos_o;

    logic         res_valid_2, hit_2, new_2, evict_2, full_2;
    logic [3:0]   id_2;
    logic [1:0]   cnt_2;
    logic [15:0]  drop_2;
    logic [7:0]   tos_2;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    phs_flow_tracker #(.FLOW_ENTRIES(16), .IN_FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .reset(reset), .phs_i(phs_i), .phs_valid_i(phs_valid_i), .flush_i(flush_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .flow_id_o(flow_id_o),
        .flow_hit_o(flow_hit_o), .flow_new_o(flow_new_o), .flow_evict_o(flow_evict_o),
        .flow_pkt_cnt_o(flow_pkt_cnt_o), .flow_tos_o(flow_tos_o), .fifo_full_o(fifo_full_o),
        .drop_cnt_o(drop_cnt_o)
    );

    // Narrow-counter instance shares all stimulus; only its saturating count is of interest.
    phs_flow_tracker #(.FLOW_ENTRIES(16), .IN_FIFO_DEPTH(4), .CNT_WIDTH(2)) dut_c2 (
        .CLK(CLK), .reset(reset), .phs_i(phs_i), .phs_valid_i(phs_valid_i), .flush_i(flush_i),
        .res_valid_o(res_valid_2), .res_ready_i(res_ready_i), .flow_id_o(id_2),
        .flow_hit_o(hit_2), .flow_new_o(new_2), .flow_evict_o(evict_2),
        .flow_pkt_cnt_o(cnt_2), .flow_tos_o(tos_2), .fifo_full_o(full_2),
        .drop_cnt_o(drop_2)
    );

    typedef struct {
        logic [3:0]  id;
        logic        hit;
        logic        newf;
        logic        evict;
        logic [15:0] cnt;
        logic [7:0]  tos;
    } exp_t;

    exp_t         sbq [$];
    logic [103:0] m_key [16];
    logic [15:0]  m_cnt [16];
    logic [15:0]  m_valid = '0;
    int           m_rr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [103:0] mk_key(input logic [31:0] sip, input logic [31:0] dip,
                                            input logic [15:0] sp, input logic [15:0] dp,
                                            input logic [7:0] pr);
        return {sp, dp, pr, sip, dip};
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_rr = 0;
    endtask

    task automatic model_flush();
        m_valid = '0;
        m_rr = 0;
    endtask

    task automatic model_pkt(input logic [103:0] key, input logic [7:0] t);
        exp_t e;
        int idx;
        int fr;
        int v;
        idx = -1;
        fr = -1;
        for (int i = 0; i < 16; i++) begin
            if (idx < 0 && m_valid[i] && m_key[i] == key) idx = i;
            if (fr < 0 && !m_valid[i]) fr = i;
        end
        e.tos = t;
        if (idx >= 0) begin
            if (m_cnt[idx] != 16'hFFFF) m_cnt[idx] = m_cnt[idx] + 16'd1;
            e.id = 4'(idx); e.hit = 1'b1; e.newf = 1'b0; e.evict = 1'b0; e.cnt = m_cnt[idx];
        end else begin
            v = (fr >= 0) ? fr : m_rr;
            e.evict = (fr < 0);
            if (fr < 0) m_rr = (m_rr + 1) % 16;
            m_key[v] = key; m_cnt[v] = 16'd1; m_valid[v] = 1'b1;
            e.id = 4'(v); e.hit = 1'b0; e.newf = 1'b1; e.cnt = 16'd1;
        end
        sbq.push_back(e);
    endtask

    task automatic send(input logic [103:0] key, input logic [7:0] t, input bit expect_result);
        if (expect_result) model_pkt(key, t);
        phs_i = {8'($urandom), t, key};
        phs_valid_i = 1'b1;
        tick();
        phs_valid_i = 1'b0;
    endtask

    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            int waited;
            exp_t e;
            logic [1:0] c2;
            waited = 0;
            res_ready_i = 1'b1;
            while (!res_valid_o && waited < 40) begin
                tick();
                waited++;
            end
            if (!res_valid_o || sbq.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL collect_wait observed valid=%0b queued=%0d required valid=1 queued>0",
                       res_valid_o, sbq.size());
            end else begin
                e = sbq.pop_front();
                c2 = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
                check("flow_id", flow_id_o, e.id);
                check("flow_hit", flow_hit_o, e.hit);
                check("flow_new", flow_new_o, e.newf);
                check("flow_evict", flow_evict_o, e.evict);
                check("pkt_cnt", flow_pkt_cnt_o, e.cnt);
                check("tos", flow_tos_o, e.tos);
                check("pkt_cnt_w2", cnt_2, c2);
                tick();
                check("valid_after_accept", res_valid_o, 1'b0);
            end
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        phs_valid_i = 1'b0;
        flush_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        sbq.delete();
    endtask

    initial begin
        logic [103:0] ka;
        logic [103:0] kb;
        int waited;
        ka = mk_key(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h11);
        kb = mk_key(32'hC0A80001, 32'hC0A80002, 16'h4000, 16'h0035, 8'h06);

        reset_dut();
        check("rst_valid", res_valid_o, 1'b0);
        check("rst_id", flow_id_o, 4'd0);
        check("rst_flags", {flow_hit_o, flow_new_o, flow_evict_o}, 3'b000);
        check("rst_cnt", flow_pkt_cnt_o, 16'd0);
        check("rst_tos", flow_tos_o, 8'd0);
        check("rst_full", fifo_full_o, 1'b0);
        check("rst_drop", drop_cnt_o, 16'd0);

        // First packet: T+4 latency, allocated in entry 0
        send(ka, 8'h00, 1'b1);
        tick();
        tick();
        check("latency_T3", res_valid_o, 1'b0);
        tick();
        check("latency_T4", res_valid_o, 1'b1);
        collect(1);

        // Same key, different TOS and tag -> hit
        send(ka, 8'h20, 1'b1);
        collect(1);

        // Fill the table, then evict round-robin
        reset_dut();
        for (int i = 0; i < 18; i++) begin
            send(mk_key(32'h0A000100 + i, 32'h0A0000FE, 16'h2000, 16'h0050, 8'h11), 8'(i), 1'b1);
            collect(1);
        end

        // Backpressure: one held result, four queued, one dropped
        reset_dut();
        res_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(mk_key(32'h0B000000 + i, 32'h0B0000FF, 16'h3000, 16'h01BB, 8'h06),
                 8'h40 + 8'(i), (i < 5));
            repeat (11) tick();
        end
        check("bp_full", fifo_full_o, 1'b1);
        check("bp_drop", drop_cnt_o, 16'd1);
        check("bp_valid_held", res_valid_o, 1'b1);
        check("bp_held_tos", flow_tos_o, sbq[0].tos);
        collect(5);
        check("bp_full_after", fifo_full_o, 1'b0);

        // Flush during lookup: in-flight result uses pre-flush table
        reset_dut();
        send(ka, 8'h01, 1'b1);
        collect(1);
        send(ka, 8'h02, 1'b1);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        model_flush();
        collect(1);
        send(ka, 8'h03, 1'b1);
        collect(1);

        // Counter saturation (narrow instance) and reset mid-result
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            send(kb, 8'h10 + 8'(i), 1'b1);
            collect(1);
        end
        res_ready_i = 1'b0;
        send(kb, 8'h55, 1'b0);
        waited = 0;
        while (!res_valid_o && waited < 40) begin
            tick();
            waited++;
        end
        check("pre_reset_valid", res_valid_o, 1'b1);
        reset = 1'b1;
        tick();
        check("reset_mid_valid", res_valid_o, 1'b0);
        check("reset_mid_valid_w2", res_valid_2, 1'b0);
        check("reset_mid_cnt", flow_pkt_cnt_o, 16'd0);
        reset = 1'b0;
        model_reset();
        sbq.delete();
        tick();
        send(kb, 8'h66, 1'b1);
        collect(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
